// File: rtl/processador_pkg.sv
// Shared definitions for the 16-bit processor datapath: opcodes, bus-select codes,
// ALU operation codes and the control-unit state encoding.
package processador_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;

  localparam logic [3:0] SEL_IMM  = 4'b1000;
  localparam logic [3:0] SEL_RES  = 4'b1001;
  localparam logic [3:0] SEL_ZERO = 4'b1111;

  localparam logic [1:0] ULA_ADD = 2'b00;
  localparam logic [1:0] ULA_SUB = 2'b01;
  localparam logic [1:0] ULA_AND = 2'b10;
  localparam logic [1:0] ULA_OR  = 2'b11;

  typedef enum logic [1:0] {
    OCIOSO = 2'b00,
    T1     = 2'b01,
    T2     = 2'b10,
    T3     = 2'b11
  } estado_t;

  function automatic logic eh_ula(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  // ALU code is the opcode offset from add; only meaningful for ALU opcodes.
  function automatic logic [1:0] ula_op_de(input logic [2:0] op);
    logic [1:0] w_op;
    case (op)
      OP_SUB:  w_op = ULA_SUB;
      OP_AND:  w_op = ULA_AND;
      OP_OR:   w_op = ULA_OR;
      default: w_op = ULA_ADD;
    endcase
    return w_op;
  endfunction

endpackage

// File: rtl/unidade_controle_if.sv
// Instruction-source / datapath-control signals of the control unit.
// The master side issues instructions; the slave side is the control unit.
interface unidade_controle_if #(
  parameter int LARGURA = 16
);
  logic               executar;
  logic [LARGURA-1:0] instrucao;
  logic [3:0]         sel;
  logic [7:0]         carrega_r;
  logic               carrega_a;
  logic               carrega_res;
  logic [1:0]         ula_op;
  logic               concluido;
  logic               invalida;
  logic               ocupado;

  modport master (
    output executar, instrucao,
    input  sel, carrega_r, carrega_a, carrega_res, ula_op,
    input  concluido, invalida, ocupado
  );

  modport slave (
    input  executar, instrucao,
    output sel, carrega_r, carrega_a, carrega_res, ula_op,
    output concluido, invalida, ocupado
  );
endinterface

// File: rtl/decodificador_reg.sv
// 3-bit register index to one-hot load enable, gated by an enable input.
module decodificador_reg (
  input  logic [2:0] i_idx,
  input  logic       i_en,
  output logic [7:0] o_onehot
);
  for (genvar gi = 0; gi < 8; gi++) begin : g_bit
    assign o_onehot[gi] = i_en && (i_idx == 3'(gi));
  end
endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: latches an instruction and sequences mv/mvi/ALU ops
// over the shared bus. Outputs are a Moore function of state and the latched word.
module unidade_controle
  import processador_pkg::*;
#(
  parameter int LARGURA = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  unidade_controle_if.slave       bus
);

  // Only opcode/rx/ry are kept; the low bits of the word never affect control.
  logic [LARGURA-1:7] r_ir;
  estado_t            r_estado;

  logic [2:0] w_op;
  logic [2:0] w_rx;
  logic [2:0] w_ry;
  logic       w_ula;
  logic       w_en_r;

  assign w_op  = r_ir[15:13];
  assign w_rx  = r_ir[12:10];
  assign w_ry  = r_ir[9:7];
  assign w_ula = eh_ula(w_op);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= OCIOSO;
      r_ir     <= '0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (bus.executar) begin
            r_ir     <= bus.instrucao[LARGURA-1:7];
            r_estado <= T1;
          end
        end
        T1:      r_estado <= w_ula ? T2 : OCIOSO;
        T2:      r_estado <= T3;
        default: r_estado <= OCIOSO;
      endcase
    end
  end

  assign w_en_r = ((r_estado == T1) && ((w_op == OP_MV) || (w_op == OP_MVI)))
               || (r_estado == T3);

  decodificador_reg u_dec (
    .i_idx    (w_rx),
    .i_en     (w_en_r),
    .o_onehot (bus.carrega_r)
  );

  always_comb begin
    bus.sel         = SEL_ZERO;
    bus.carrega_a   = 1'b0;
    bus.carrega_res = 1'b0;
    bus.ula_op      = ULA_ADD;
    bus.concluido   = 1'b0;
    bus.invalida    = 1'b0;
    bus.ocupado     = (r_estado != OCIOSO);
    if (r_estado != OCIOSO && w_ula) begin
      bus.ula_op = ula_op_de(w_op);
    end
    case (r_estado)
      T1: begin
        if (w_op == OP_MV) begin
          bus.sel       = {1'b0, w_ry};
          bus.concluido = 1'b1;
        end else if (w_op == OP_MVI) begin
          bus.sel       = SEL_IMM;
          bus.concluido = 1'b1;
        end else if (w_ula) begin
          bus.sel       = {1'b0, w_rx};
          bus.carrega_a = 1'b1;
        end else begin
          bus.concluido = 1'b1;
          bus.invalida  = 1'b1;
        end
      end
      T2: begin
        bus.sel         = {1'b0, w_ry};
        bus.carrega_res = 1'b1;
      end
      T3: begin
        bus.sel       = SEL_RES;
        bus.concluido = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Directed table-driven check of unidade_controle: each row gives the inputs
// present at a rising edge and the outputs expected during the following cycle.
module tb_unidade_controle;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  unidade_controle_if #(.LARGURA(16)) bus ();

  unidade_controle #(.LARGURA(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        ex;
    logic [15:0] ins;
    logic [3:0]  sel;
    logic [7:0]  cr;
    logic        ca;
    logic        cres;
    logic [1:0]  op;
    logic        conc;
    logic        inv;
    logic        ocup;
  } vec_t;

  vec_t tbl[80];
  int   n_vec = 0;

  task automatic add(input logic rst, input logic ex, input logic [15:0] ins,
                     input logic [3:0] sel, input logic [7:0] cr, input logic ca,
                     input logic cres, input logic [1:0] op, input logic conc,
                     input logic inv, input logic ocup);
    tbl[n_vec] = '{rst, ex, ins, sel, cr, ca, cres, op, conc, inv, ocup};
    n_vec++;
  endtask

  task automatic idle(input logic rst, input logic ex, input logic [15:0] ins);
    add(rst, ex, ins, 4'hF, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int cyc;

    bus.executar  = 1'b0;
    bus.instrucao = 16'h0000;

    // reset then idle for 5 cycles
    idle(1, 0, 16'h0000);
    idle(1, 1, 16'h4900);
    for (int i = 0; i < 5; i++) idle(0, 0, 16'h0000);
    // mv r3,r5
    add(0, 1, 16'h0E80, 4'h5, 8'h08, 0, 0, 2'b00, 1, 0, 1);
    idle(0, 0, 16'h0000);
    // sub r1,r6
    add(0, 1, 16'h6700, 4'h1, 8'h00, 1, 0, 2'b01, 0, 0, 1);
    add(0, 0, 16'h0000, 4'h6, 8'h00, 0, 1, 2'b01, 0, 0, 1);
    add(0, 0, 16'h0000, 4'h9, 8'h02, 0, 0, 2'b01, 1, 0, 1);
    idle(0, 0, 16'h0000);
    // illegal 111 and 110
    add(0, 1, 16'hE000, 4'hF, 8'h00, 0, 0, 2'b00, 1, 1, 1);
    idle(0, 0, 16'h0000);
    add(0, 1, 16'hC000, 4'hF, 8'h00, 0, 0, 2'b00, 1, 1, 1);
    idle(0, 0, 16'h0000);
    // mvi r7
    add(0, 1, 16'h3C00, 4'h8, 8'h80, 0, 0, 2'b00, 1, 0, 1);
    idle(0, 0, 16'h0000);
    // and r0,r4
    add(0, 1, 16'h8200, 4'h0, 8'h00, 1, 0, 2'b10, 0, 0, 1);
    add(0, 0, 16'h0000, 4'h4, 8'h00, 0, 1, 2'b10, 0, 0, 1);
    add(0, 0, 16'h0000, 4'h9, 8'h01, 0, 0, 2'b10, 1, 0, 1);
    idle(0, 0, 16'h0000);
    // executar held high, instrucao changing during add r2,r2
    add(0, 1, 16'h4900, 4'h2, 8'h00, 1, 0, 2'b00, 0, 0, 1);
    add(0, 1, 16'h0E80, 4'h2, 8'h00, 0, 1, 2'b00, 0, 0, 1);
    add(0, 1, 16'h6700, 4'h9, 8'h04, 0, 0, 2'b00, 1, 0, 1);
    idle(0, 1, 16'hE000);
    add(0, 1, 16'h3C00, 4'h8, 8'h80, 0, 0, 2'b00, 1, 0, 1);
    idle(0, 1, 16'h0E80);
    add(0, 1, 16'h0E80, 4'h5, 8'h08, 0, 0, 2'b00, 1, 0, 1);
    idle(0, 0, 16'h0000);
    // or r5,r1 interrupted by reset in T2 (reset beats executar)
    add(0, 1, 16'hB480, 4'h5, 8'h00, 1, 0, 2'b11, 0, 0, 1);
    add(0, 0, 16'h0000, 4'h1, 8'h00, 0, 1, 2'b11, 0, 0, 1);
    idle(1, 1, 16'h0E80);
    idle(0, 0, 16'h0000);
    idle(0, 0, 16'h0000);
    // or r5,r1 uninterrupted
    add(0, 1, 16'hB480, 4'h5, 8'h00, 1, 0, 2'b11, 0, 0, 1);
    add(0, 0, 16'h0000, 4'h1, 8'h00, 0, 1, 2'b11, 0, 0, 1);
    add(0, 0, 16'h0000, 4'h9, 8'h20, 0, 0, 2'b11, 1, 0, 1);
    idle(0, 0, 16'h0000);

    for (int i = 0; i < n_vec; i++) begin
      int e0;
      e0 = n_err;
      reset         = tbl[i].rst;
      bus.executar  = tbl[i].ex;
      bus.instrucao = tbl[i].ins;
      tick();
      chk("sel",         i, 16'(bus.sel),         16'(tbl[i].sel));
      chk("carrega_r",   i, 16'(bus.carrega_r),   16'(tbl[i].cr));
      chk("carrega_a",   i, 16'(bus.carrega_a),   16'(tbl[i].ca));
      chk("carrega_res", i, 16'(bus.carrega_res), 16'(tbl[i].cres));
      chk("ula_op",      i, 16'(bus.ula_op),      16'(tbl[i].op));
      chk("concluido",   i, 16'(bus.concluido),   16'(tbl[i].conc));
      chk("invalida",    i, 16'(bus.invalida),    16'(tbl[i].inv));
      chk("ocupado",     i, 16'(bus.ocupado),     16'(tbl[i].ocup));
      $display("row %0d: rst=%0b ex=%0b ins=%h -> sel=%h cr=%h a=%0b res=%0b op=%0d conc=%0b inv=%0b ocup=%0b %s",
               i, tbl[i].rst, tbl[i].ex, tbl[i].ins, bus.sel, bus.carrega_r,
               bus.carrega_a, bus.carrega_res, bus.ula_op, bus.concluido,
               bus.invalida, bus.ocupado, (n_err == e0) ? "ok" : "bad");
    end

    // Latency of an ALU op measured with a bounded wait on concluido.
    reset         = 1'b0;
    bus.executar  = 1'b1;
    bus.instrucao = 16'h8200;
    tick();
    bus.executar  = 1'b0;
    cyc = 1;
    while (!bus.concluido && cyc < 8) begin
      tick();
      cyc++;
    end
    chk("alu_latency", n_vec, 16'(cyc), 16'd3);
    chk("t3_sel",      n_vec, 16'(bus.sel), 16'h9);
    chk("t3_load",     n_vec, 16'(bus.carrega_r), 16'h01);
    tick();
    chk("after_t3",    n_vec, 16'(bus.ocupado), 16'd0);
    $display("latency seq: and r0,r4 concluido after %0d edges", cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
